// File: rtl/ats_pkg.sv
// Shared types for the ATS command intake: opcodes, error codes, intake FSM states
// and instruction field positions.
package ats_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SET_CLK   = 3'b001,
        OP_BC_EN     = 3'b010,
        OP_MODE      = 3'b011,
        OP_RSVD      = 3'b100,
        OP_SET_ALARM = 3'b101,
        OP_SET_CDT   = 3'b110,
        OP_AT_EN     = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_DROP     = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_REQ_LOW  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HOLD = 2'b10
    } intake_state_e;

    // Field positions inside the upper halfword
    localparam int CLK_NUM_MSB   = 12;
    localparam int CLK_NUM_LSB   = 9;
    localparam int ALARM_NUM_MSB = 12;
    localparam int ALARM_NUM_LSB = 8;
    localparam int RATE_MSB      = 7;
    localparam int RATE_LSB      = 6;

    function automatic logic op_is_nop(input logic [2:0] op);
        return opcode_e'(op) == OP_NOP;
    endfunction

    function automatic logic op_is_rsvd(input logic [2:0] op);
        return opcode_e'(op) == OP_RSVD;
    endfunction

endpackage

// File: rtl/ats_cmd_fifo.sv
// Synchronous FIFO for completed commands; the head reads as zero while empty.
module ats_cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ats_cmd_intake.sv
// ATS command front-end: per-client two-halfword capture, round-robin arbitration into a FIFO.
// Define ATS_ILLEGAL_OP_FILTER_EN to drop reserved opcode 100 with an error pulse.
module ats_cmd_intake
    import ats_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int WORD_W      = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CLIENTS-1:0]              req,
    input  logic [NUM_CLIENTS-1:0][WORD_W-1:0]  ctrl,
    output logic [NUM_CLIENTS-1:0]              ready,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    output logic [2*WORD_W-1:0]                 cmd_word,
    output logic [2:0]                          cmd_op,
    output logic [$clog2(NUM_CLIENTS)-1:0]      cmd_client,
    output logic                                err_valid,
    output logic [1:0]                          err_code,
    output logic [$clog2(NUM_CLIENTS)-1:0]      err_client
);

    localparam int CID_W   = $clog2(NUM_CLIENTS);
    localparam int INSTR_W = 2 * WORD_W;
    localparam int ENTRY_W = INSTR_W + CID_W;

`ifdef ATS_ILLEGAL_OP_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    intake_state_e     state [NUM_CLIENTS];
    logic [WORD_W-1:0] upper [NUM_CLIENTS];
    logic [WORD_W-1:0] lower [NUM_CLIENTS];
    err_code_e         cli_err [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] hold;
    logic [NUM_CLIENTS-1:0] discard;

    logic             err_hit;
    err_code_e        err_sel_code;
    logic [CID_W-1:0] err_sel_id;

    logic [CID_W-1:0] last_grant;
    logic [CID_W-1:0] grant_id;
    logic             grant_vld;
    logic             can_push;
    logic             pop;
    int               idx;

    logic                              fifo_full;
    logic                              fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    logic [ENTRY_W-1:0]                fifo_head;

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            hold[i]    = (state[i] == ST_HOLD);
            ready[i]   = (state[i] == ST_IDLE) && !reset;
            discard[i] = op_is_nop(upper[i][WORD_W-1 -: 3]) ||
                         (FILTER_EN && op_is_rsvd(upper[i][WORD_W-1 -: 3]));
            cli_err[i] = ERR_NONE;
            if (state[i] == ST_LOW && FILTER_EN && op_is_rsvd(upper[i][WORD_W-1 -: 3]))
                cli_err[i] = ERR_ILLEGAL;
            else if (state[i] == ST_LOW && req[i])
                cli_err[i] = ERR_REQ_LOW;
            else if (state[i] == ST_HOLD && req[i])
                cli_err[i] = ERR_DROP;
        end
    end

    // Descending scan so the lowest-index offender wins
    always_comb begin
        err_hit      = 1'b0;
        err_sel_code = ERR_NONE;
        err_sel_id   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (cli_err[i] != ERR_NONE) begin
                err_hit      = 1'b1;
                err_sel_code = cli_err[i];
                err_sel_id   = CID_W'(i);
            end
        end
    end

    assign pop      = cmd_ready && !fifo_empty;
    assign can_push = !fifo_full || pop;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_CLIENTS;
            if (!grant_vld && hold[idx] && can_push && !reset) begin
                grant_vld = 1'b1;
                grant_id  = CID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (reset) begin
                state[i] <= ST_IDLE;
            end else begin
                case (state[i])
                    ST_IDLE: if (req[i]) state[i] <= ST_LOW;
                    ST_LOW:  state[i] <= discard[i] ? ST_IDLE : ST_HOLD;
                    ST_HOLD: if (grant_vld && grant_id == CID_W'(i)) state[i] <= ST_IDLE;
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // Halfword capture registers carry no reset; the FSM state qualifies them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (state[i] == ST_IDLE && req[i]) upper[i] <= ctrl[i];
            if (state[i] == ST_LOW)            lower[i] <= ctrl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= CID_W'(NUM_CLIENTS - 1);
            err_valid  <= 1'b0;
            err_code   <= 2'b00;
            err_client <= '0;
        end else begin
            if (grant_vld) last_grant <= grant_id;
            err_valid  <= err_hit;
            err_code   <= err_sel_code;
            err_client <= err_sel_id;
        end
    end

    ats_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_vld),
        .push_data ({upper[grant_id], lower[grant_id], grant_id}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_valid  = (fifo_count != '0);
    assign cmd_word   = fifo_head[ENTRY_W-1 -: INSTR_W];
    assign cmd_op     = cmd_word[INSTR_W-1 -: 3];
    assign cmd_client = fifo_head[CID_W-1:0];

endmodule

// File: tb/tb_ats_cmd_intake.sv
// Directed bench for ats_cmd_intake (4 clients, 4-deep FIFO) with a word scoreboard.
module tb_ats_cmd_intake;

    localparam int NC = 4;
    localparam int WW = 16;
    localparam int FD = 4;
    localparam int CW = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NC-1:0]           req;
    logic [NC-1:0][WW-1:0]   ctrl;
    logic [NC-1:0]           ready;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2*WW-1:0]         cmd_word;
    logic [2:0]              cmd_op;
    logic [CW-1:0]           cmd_client;
    logic                    err_valid;
    logic [1:0]              err_code;
    logic [CW-1:0]           err_client;

    int checks = 0;
    int errors = 0;
    logic [31:0]   exp_word_q [$];
    logic [CW-1:0] exp_cli_q  [$];

    ats_cmd_intake #(.NUM_CLIENTS(NC), .WORD_W(WW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ctrl       (ctrl),
        .ready      (ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_word   (cmd_word),
        .cmd_op     (cmd_op),
        .cmd_client (cmd_client),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_client (err_client)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [CW-1:0] c);
        exp_word_q.push_back(w);
        exp_cli_q.push_back(c);
    endtask

    // Scoreboard the handshake at the falling edge, then move to just after the next rising edge
    task automatic step();
        logic [31:0]   w;
        logic [CW-1:0] c;
        @(negedge clk);
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            check("sb_expected", 64'(exp_word_q.size() != 0), 64'd1);
            if (exp_word_q.size() != 0) begin
                w = exp_word_q.pop_front();
                c = exp_cli_q.pop_front();
                check("sb_word", 64'(cmd_word), 64'(w));
                check("sb_op", 64'(cmd_op), 64'(w[31:29]));
                check("sb_client", 64'(cmd_client), 64'(c));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives upper halves with req, then lower halves; returns in cycle t+2
    task automatic two_half(input logic [NC-1:0] mask, input logic [NC-1:0][31:0] words,
                            input logic [NC-1:0] req_low);
        req = mask;
        for (int i = 0; i < NC; i++) ctrl[i] = words[i][31:16];
        step();
        check("ready_low_cycle", 64'(ready & mask), 64'd0);
        req = req_low;
        for (int i = 0; i < NC; i++) ctrl[i] = words[i][15:0];
        step();
        req = '0;
        ctrl = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_word_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_complete", 64'(exp_word_q.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req = '0;
        ctrl = '0;
        cmd_ready = 1'b1;
        step();
        step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_word", 64'(cmd_word), 64'd0);
        check("rst_cmd_op", 64'(cmd_op), 64'd0);
        check("rst_cmd_client", 64'(cmd_client), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_err_client", 64'(err_client), 64'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", 64'(ready), 64'hf);

        // Simultaneous pair after reset: client 0 has priority
        expect_word(32'h2000_0000, 2'd0);
        expect_word(32'h2240_0000, 2'd1);
        two_half(4'b0011, {32'h0, 32'h0, 32'h2240_0000, 32'h2000_0000}, 4'b0000);
        step();
        check("pair1_first_valid", 64'(cmd_valid), 64'd1);
        check("pair1_first_client", 64'(cmd_client), 64'd0);
        wait_drain(20);

        // Single word latency: cmd_valid at t+3
        expect_word(32'h2080_0000, 2'd0);
        two_half(4'b0001, {32'h0, 32'h0, 32'h0, 32'h2080_0000}, 4'b0000);
        check("single_t2_valid", 64'(cmd_valid), 64'd0);
        step();
        check("single_t3_valid", 64'(cmd_valid), 64'd1);
        check("single_t3_word", 64'(cmd_word), 64'h2080_0000);
        check("single_t3_op", 64'(cmd_op), 64'd1);
        check("single_t3_client", 64'(cmd_client), 64'd0);
        check("single_t3_ready0", 64'(ready[0]), 64'd1);
        wait_drain(20);

        // Last grant was client 0, so client 1 now wins a simultaneous pair
        expect_word(32'h2240_0000, 2'd1);
        expect_word(32'h2000_0000, 2'd0);
        two_half(4'b0011, {32'h0, 32'h0, 32'h2240_0000, 32'h2000_0000}, 4'b0000);
        step();
        check("pair2_first_client", 64'(cmd_client), 64'd1);
        wait_drain(20);

        // Nop from client 1 is discarded silently
        two_half(4'b0010, {32'h0, 32'h0, 32'h0000_abcd, 32'h0}, 4'b0000);
        check("nop_ready1_t2", 64'(ready[1]), 64'd1);
        check("nop_err_valid", 64'(err_valid), 64'd0);
        step();
        check("nop_no_push", 64'(cmd_valid), 64'd0);

        // req during LOW from clients 1 and 2: lowest index reported, words still forwarded
        expect_word(32'h5a00_1234, 2'd1);
        expect_word(32'hc000_00ff, 2'd2);
        two_half(4'b0110, {32'h0, 32'hc000_00ff, 32'h5a00_1234, 32'h0}, 4'b0110);
        check("reqlow_err_valid", 64'(err_valid), 64'd1);
        check("reqlow_err_code", 64'(err_code), 64'd3);
        check("reqlow_err_client", 64'(err_client), 64'd1);
        step();
        check("reqlow_err_pulse", 64'(err_valid), 64'd0);
        wait_drain(20);
        check("reqlow_ready_after", 64'(ready), 64'hf);

        // Reserved opcode 100
`ifdef ATS_ILLEGAL_OP_FILTER_EN
        two_half(4'b0001, {32'h0, 32'h0, 32'h0, 32'h8000_0000}, 4'b0000);
        check("rsvd_err_valid", 64'(err_valid), 64'd1);
        check("rsvd_err_code", 64'(err_code), 64'd2);
        check("rsvd_err_client", 64'(err_client), 64'd0);
        step();
        check("rsvd_no_push", 64'(cmd_valid), 64'd0);
        step();
`else
        expect_word(32'h8000_0000, 2'd0);
        two_half(4'b0001, {32'h0, 32'h0, 32'h0, 32'h8000_0000}, 4'b0000);
        check("rsvd_err_valid", 64'(err_valid), 64'd0);
        step();
        check("rsvd_fwd_word", 64'(cmd_word), 64'h8000_0000);
        wait_drain(20);
`endif

        // Reset during the lower-half cycle discards the capture
        check("pre_rst_queue", 64'(exp_word_q.size()), 64'd0);
        req = 4'b1000;
        ctrl[3] = 16'h2080;
        step();
        req = '0;
        ctrl[3] = 16'h0000;
        reset = 1'b1;
        step();
        check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        reset = 1'b0;
        step();
        check("midrst_release_ready", 64'(ready), 64'hf);
        for (int i = 0; i < 4; i++) step();
        check("midrst_no_stale", 64'(cmd_valid), 64'd0);

        // Backpressure: four words fill the FIFO, two more wait in HOLD
        cmd_ready = 1'b0;
        expect_word(32'h2100_0001, 2'd0);
        expect_word(32'h4200_0002, 2'd1);
        expect_word(32'h6300_0003, 2'd2);
        expect_word(32'ha400_0004, 2'd3);
        expect_word(32'he500_0005, 2'd0);
        expect_word(32'h2600_0006, 2'd1);
        two_half(4'b1111, {32'ha400_0004, 32'h6300_0003, 32'h4200_0002, 32'h2100_0001}, 4'b0000);
        for (int i = 0; i < 6; i++) step();
        check("bp_ready_all", 64'(ready), 64'hf);
        two_half(4'b0011, {32'h0, 32'h0, 32'h2600_0006, 32'he500_0005}, 4'b0000);
        step();
        check("bp_head_valid", 64'(cmd_valid), 64'd1);
        check("bp_head_stable", 64'(cmd_word), 64'h2100_0001);
        check("bp_hold_ready", 64'(ready), 64'b1100);
        req = 4'b0001;
        ctrl[0] = 16'h3333;
        step();
        req = '0;
        ctrl = '0;
        check("drop_err_valid", 64'(err_valid), 64'd1);
        check("drop_err_code", 64'(err_code), 64'd1);
        check("drop_err_client", 64'(err_client), 64'd0);
        check("drop_ready", 64'(ready), 64'b1100);
        cmd_ready = 1'b1;
        wait_drain(40);
        check("bp_final_ready", 64'(ready), 64'hf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ats_cmd_intake.md
# ats_cmd_intake

Parametrised command front-end for the ATS alarm/timer core. Captures two-halfword instructions from NUM_CLIENTS independent clients, upper half in the req cycle and lower half the next, discards Nops, and round-robin arbitrates completed words into a shared FIFO. The FIFO feeds the core through a valid/ready handshake. It replaces the fixed two-client, shared-req capture logic of the current design.

## Interface
- NUM_CLIENTS, 2: number of clients, 2..8.
- WORD_W, 16: halfword width; the instruction is 2*WORD_W bits.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, at least 2.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CLIENTS  per-client request strobe, sampled with the upper halfword.
- ctrl  in  NUM_CLIENTS x WORD_W (packed)  per-client halfword bus.
- ready  out  NUM_CLIENTS  client i may start a request this cycle.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ready  in  1  core accepts the head.
- cmd_word  out  2*WORD_W  instruction, {upper, lower}.
- cmd_op  out  3  cmd_word[2*WORD_W-1 -: 3].
- cmd_client  out  $clog2(NUM_CLIENTS)  originating client.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 = dropped req (not ready), 10 = illegal opcode, 11 = req during lower-half cycle.
- err_client  out  $clog2(NUM_CLIENTS)  offending client.

## Operation
- Per-client FSM with states IDLE, LOW and HOLD.
- IDLE: on req[i], latch ctrl[i] as upper and go to LOW.
- LOW: latch ctrl[i] as lower, with 3 opcode bits = upper[WORD_W-1:WORD_W-3].
  - Opcode 000 (Nop): discard and return to IDLE. No error.
  - Otherwise go to HOLD.
  - If req[i] is high in LOW: lower is still captured, err_code 11 is pulsed, and the req does not start a new capture.
- HOLD: the word waits for a grant; on grant return to IDLE.
- ready[i] = (state==IDLE) && !reset.
- req[i] while in HOLD: request ignored, err_code 01 pulsed.
- Arbiter:
  - Considers clients in HOLD, at most one grant per cycle.
  - Round-robin starting at last_grant+1 mod NUM_CLIENTS; last_grant resets to NUM_CLIENTS-1, so client 0 has first priority.
  - A grant is issued only when the FIFO can accept: !full, or full with a pop in the same cycle.
  - Grant pushes {upper, lower, client id}.
- FIFO:
  - Head drives cmd_word, cmd_op and cmd_client.
  - Pop when cmd_valid && cmd_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).
- Simultaneous errors from several clients: report the lowest-index client; the others are lost.
- Reset values: ready = 0 (while reset is high), cmd_valid = 0, cmd_word = 0, cmd_op = 0, cmd_client = 0, err_valid = 0, err_code = 0, err_client = 0. All FSMs return to IDLE and the FIFO is emptied.
- Reset asserted mid-capture or mid-HOLD discards the partial or held word; no error is reported.

## Timing
- Cycle t: req[i]=1 with upper on ctrl[i].
- Cycle t+1: lower on ctrl[i]; ready[i]=0.
- Cycle t+2: HOLD, grant when uncontended, push at the end of the cycle.
- Cycle t+3: cmd_valid=1 (FIFO previously empty); ready[i]=1.
- Minimum req spacing per client is 3 cycles.
- err_valid is asserted the cycle after the offending sample.
- cmd_* outputs hold stable while cmd_valid && !cmd_ready.

## Configuration
- ATS_ILLEGAL_OP_FILTER_EN defined: opcode 100 (reserved) is discarded in LOW, FSM returns to IDLE, err_code 10 pulsed. It never reaches the FIFO.
- Not defined: opcode 100 is forwarded like any other non-Nop opcode, and err_code 10 is never produced.

## Structure
- Package ats_pkg holds:
  - opcode enum: OP_NOP=000, OP_SET_CLK=001, OP_BC_EN=010, OP_MODE=011, OP_RSVD=100, OP_SET_ALARM=101, OP_SET_CDT=110, OP_AT_EN=111;
  - error code enum;
  - intake FSM state enum;
  - field position constants (clock # [12:9], alarm # [12:8], rate [7:6]).
- Sub-module ats_cmd_fifo: a parametrised synchronous FIFO with width, depth, full, empty and count.

## Test plan
- Client 0 sends 32'h2080_0000 (set clock 0, 4X), FIFO empty, cmd_ready=1: cmd_valid at t+3 with cmd_word=32'h2080_0000, cmd_op=001, cmd_client=0.
- NUM_CLIENTS=2, both clients req in the same cycle (0: 32'h2000_0000, 1: 32'h2240_0000): client 0's word is popped first, then client 1's; the next simultaneous pair is delivered client 1 first.
- Client 1 sends upper 16'h0000: no FIFO push, no error, ready[1] high again at t+2.
- cmd_ready=0, NUM_CLIENTS=4, FIFO_DEPTH=4, six words issued: FIFO holds 4 and 2 clients sit in HOLD. Re-req from a HOLD client gives err_code=01. After cmd_ready=1, all 6 words drain in arbitration order with none lost.
- With ATS_ILLEGAL_OP_FILTER_EN, client 0 sends 32'h8000_0000: err_valid=1, err_code=10, err_client=0 at t+2 and no push. Without the macro, the word appears on cmd_word.
- Reset asserted at t+1 of a capture: the next cycle has cmd_valid=0 and ready=0. After release, ready goes to all 1s and no stale word is ever output.
